// File: rtl/interrupt_ack_sequencer.sv
// Interrupt-cycle controller: IRR capture, rotating-priority resolution against ISR,
// two-pulse INTA acknowledge sequencing and OCW2 EOI/rotation command execution.
module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       inta_n,
    input  logic       ocw2_valid,
    input  logic [7:0] ocw2,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] lowest_level
);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2} state_t;

    state_t     r_state, w_state_n;
    logic [7:0] r_ir_prev, r_irr, r_isr, r_data_out;
    logic       r_inta_prev, r_int, r_data_oe, r_aeoi_rotate, r_spurious;
    logic [2:0] r_lowest, r_ack_level;

    logic [7:0] w_irr_n, w_isr_n, w_ack_set, w_eoi_clear, w_aeoi_clear, w_data_out_n;
    logic [2:0] w_lowest_n, w_ack_level_n, w_cand, w_isr_hi;
    logic       w_data_oe_n, w_aeoi_rot_n, w_spurious_n;
    logic       w_cand_found, w_isr_found, w_eligible, w_inta_fall, w_inta_rise;
    logic       w_unused_ocw2;

    // Walks from lowest to highest priority so the last hit is the highest-priority bit.
    function automatic logic [3:0] f_first(input logic [7:0] v, input logic [2:0] low);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = low - 3'(i);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] low);
        return lvl - low - 3'd1;
    endfunction

    assign w_unused_ocw2 = ^ocw2[4:3];
    assign w_inta_fall   = r_inta_prev & ~inta_n;
    assign w_inta_rise   = ~r_inta_prev & inta_n;

    always_comb begin
        {w_cand_found, w_cand}  = f_first(r_irr & ~imr, r_lowest);
        {w_isr_found, w_isr_hi} = f_first(r_isr, r_lowest);
        w_eligible = w_cand_found &
                     (~w_isr_found | (f_rank(w_cand, r_lowest) < f_rank(w_isr_hi, r_lowest)));
    end

    always_comb begin
        w_state_n     = r_state;
        w_ack_set     = '0;
        w_eoi_clear   = '0;
        w_aeoi_clear  = '0;
        w_lowest_n    = r_lowest;
        w_aeoi_rot_n  = r_aeoi_rotate;
        w_ack_level_n = r_ack_level;
        w_spurious_n  = r_spurious;
        w_data_out_n  = r_data_out;
        w_data_oe_n   = r_data_oe;

        case (r_state)
            S_IDLE: if (w_inta_fall) begin
                w_state_n = S_ACK1;
                if (w_eligible) begin
                    w_ack_set     = 8'b1 << w_cand;
                    w_ack_level_n = w_cand;
                    w_spurious_n  = 1'b0;
                end else begin
                    w_ack_level_n = 3'd7;
                    w_spurious_n  = 1'b1;
                end
            end
            S_ACK1: if (w_inta_rise) w_state_n = S_GAP;
            S_GAP: if (w_inta_fall) begin
                w_state_n    = S_ACK2;
                w_data_out_n = {vector_base, r_ack_level};
                w_data_oe_n  = 1'b1;
            end
            S_ACK2: if (w_inta_rise) begin
                w_state_n   = S_IDLE;
                w_data_oe_n = 1'b0;
                if (auto_eoi && !r_spurious) begin
                    w_aeoi_clear = 8'b1 << r_ack_level;
                    if (r_aeoi_rotate) w_lowest_n = r_ack_level;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // Evaluated after the ack logic so an OCW2 rotation overrides an AEOI rotation.
        if (ocw2_valid) begin
            case (ocw2[7:5])
                3'b001: if (w_isr_found) w_eoi_clear = 8'b1 << w_isr_hi;
                3'b011: w_eoi_clear = 8'b1 << ocw2[2:0];
                3'b101: if (w_isr_found) begin
                    w_eoi_clear = 8'b1 << w_isr_hi;
                    w_lowest_n  = w_isr_hi;
                end
                3'b111: begin
                    w_eoi_clear = 8'b1 << ocw2[2:0];
                    w_lowest_n  = ocw2[2:0];
                end
                3'b110: w_lowest_n = ocw2[2:0];
                3'b100: w_aeoi_rot_n = 1'b1;
                3'b000: w_aeoi_rot_n = 1'b0;
                default: ;
            endcase
        end

        w_irr_n = (ltim ? ir : (r_irr | (ir & ~r_ir_prev))) & ~w_ack_set;
        w_isr_n = (r_isr & ~w_eoi_clear & ~w_aeoi_clear) | w_ack_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ir_prev     <= '0;
            r_inta_prev   <= 1'b1;
            r_irr         <= '0;
            r_isr         <= '0;
            r_int         <= 1'b0;
            r_data_out    <= '0;
            r_data_oe     <= 1'b0;
            r_lowest      <= 3'd7;
            r_aeoi_rotate <= 1'b0;
            r_ack_level   <= 3'd7;
            r_spurious    <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ir_prev     <= ir;
            r_inta_prev   <= inta_n;
            r_irr         <= w_irr_n;
            r_isr         <= w_isr_n;
            r_int         <= (r_state == S_IDLE) & w_eligible;
            r_data_out    <= w_data_out_n;
            r_data_oe     <= w_data_oe_n;
            r_lowest      <= w_lowest_n;
            r_aeoi_rotate <= w_aeoi_rot_n;
            r_ack_level   <= w_ack_level_n;
            r_spurious    <= w_spurious_n;
        end
    end

    assign int_out      = r_int;
    assign data_out     = r_data_out;
    assign data_oe      = r_data_oe;
    assign irr          = r_irr;
    assign isr          = r_isr;
    assign lowest_level = r_lowest;

endmodule
